// File: rtl/rc_model_pkg.sv
// rc_model_pkg: default constants and accumulator sizing for the RC filter
package rc_model_pkg;
  localparam int RC_WIDTH_DEF = 8;
  localparam int RC_SHIFT_DEF = 3;
  function automatic int acc_width(input int width, input int shift);
    return width + shift;
  endfunction
endpackage

// File: rtl/rc_model_if.sv
// rc_model_if: sample in / filtered sample out bundle; settled exists only with RC_MODEL_SETTLED_EN
interface rc_model_if
  import rc_model_pkg::*;
#(
  parameter int WIDTH = RC_WIDTH_DEF
);
  logic [WIDTH-1:0] v_in;
  logic [WIDTH-1:0] v_out;
`ifdef RC_MODEL_SETTLED_EN
  logic settled;
  modport master(output v_in, input v_out, input settled);
  modport slave(input v_in, output v_out, output settled);
`else
  modport master(output v_in, input v_out);
  modport slave(input v_in, output v_out);
`endif
endinterface

// File: rtl/rc_leak_step.sv
// rc_leak_step: combinational leaky-integrator update acc + v_in - (acc >> SHIFT)
module rc_leak_step
  import rc_model_pkg::*;
#(
  parameter int WIDTH = RC_WIDTH_DEF,
  parameter int SHIFT = RC_SHIFT_DEF,
  localparam int AW = acc_width(WIDTH, SHIFT)
) (
  input  logic [AW-1:0]    acc,
  input  logic [WIDTH-1:0] v_in,
  output logic [AW-1:0]    acc_next
);
  logic [AW:0] sum;
  // one extra bit holds acc + v_in before the leak is removed
  always_comb begin
    sum = {1'b0, acc} + {{(SHIFT + 1){1'b0}}, v_in} - {1'b0, acc >> SHIFT};
    acc_next = AW'(sum);
  end
endmodule

// File: rtl/rc_model.sv
// rc_model: first-order RC low-pass filter as an unsigned leaky integrator (optional settled flag via RC_MODEL_SETTLED_EN)
module rc_model
  import rc_model_pkg::*;
#(
  parameter int WIDTH = RC_WIDTH_DEF,
  parameter int SHIFT = RC_SHIFT_DEF
) (
  input logic clk,
  input logic rst,
  rc_model_if.slave bus
);
  localparam int AW = acc_width(WIDTH, SHIFT);
  logic [AW-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] v_out_q, v_out_d;
  rc_leak_step #(.WIDTH(WIDTH), .SHIFT(SHIFT)) u_step (
    .acc(acc_q),
    .v_in(bus.v_in),
    .acc_next(acc_d)
  );
  // output register tracks the next accumulator so v_out always equals acc >> SHIFT
  always_comb v_out_d = WIDTH'(acc_d >> SHIFT);
  // filter state, cleared by the active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      v_out_q <= '0;
    end else begin
      acc_q <= acc_d;
      v_out_q <= v_out_d;
    end
  end
  assign bus.v_out = v_out_q;
`ifdef RC_MODEL_SETTLED_EN
  localparam logic [SHIFT:0] FULL = (SHIFT + 1)'(1 << SHIFT);
  logic [WIDTH-1:0] vin_prev_q, vin_prev_d;
  logic [SHIFT:0] cnt_q, cnt_d;
  logic settled_q, settled_d;
  // count consecutive quiet cycles, restarting whenever input or output moves
  always_comb begin
    vin_prev_d = bus.v_in;
    cnt_d = (bus.v_in == vin_prev_q && v_out_d == v_out_q) ? (cnt_q == FULL ? cnt_q : cnt_q + 1'b1) : '0;
    settled_d = cnt_d == FULL && v_out_d == bus.v_in;
  end
  // settle-detector state
  always_ff @(posedge clk) begin
    if (!rst) begin
      vin_prev_q <= '0;
      cnt_q <= '0;
      settled_q <= 1'b0;
    end else begin
      vin_prev_q <= vin_prev_d;
      cnt_q <= cnt_d;
      settled_q <= settled_d;
    end
  end
  assign bus.settled = settled_q;
`endif
endmodule

// File: tb/tb_rc_model.sv
// tb_rc_model: scoreboard bench for rc_model (WIDTH=8, SHIFT=3)
module tb_rc_model;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int macc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got, exp_v, prev;
  always #5 clk = ~clk;
  rc_model_if #(.WIDTH(8)) bus ();
  rc_model #(.WIDTH(8), .SHIFT(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic cyc(input logic [7:0] v, input logic r);
    bus.v_in = v;
    rst = r;
    macc = !r ? 0 : macc + int'(v) - (macc >> 3);
    exp_q.push_back(8'(macc >> 3));
    @(posedge clk);
    #1;
    got = bus.v_out;
    exp_v = exp_q.pop_front();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(8'd100, 1'b0);
      checks++;
      if (got !== 8'd0) begin
        errors++;
        $display("FAIL reset cyc%0d v_out=%0d expected=0", i, got);
      end
    end
  endtask

  task automatic test_zero();
    for (int i = 0; i < 64; i++) begin
      cyc(8'd0, 1'b1);
      checks++;
      if (got !== 8'd0 || got !== exp_v) begin
        errors++;
        $display("FAIL zero cyc%0d v_out=%0d expected=%0d", i, got, exp_v);
      end
`ifdef RC_MODEL_SETTLED_EN
      if (i >= 7) begin
        checks++;
        if (bus.settled !== 1'b1) begin
          errors++;
          $display("FAIL settled cyc%0d settled=%b expected=1", i, bus.settled);
        end
      end
`endif
    end
  endtask

  task automatic test_step_up();
    logic [7:0] first [4] = '{8'd8, 8'd15, 8'd21, 8'd26};
    prev = 8'd0;
    for (int i = 0; i < 48; i++) begin
      cyc(8'd64, 1'b1);
      checks++;
      if (got !== exp_v || got < prev || got > 8'd64) begin
        errors++;
        $display("FAIL step_up cyc%0d v_out=%0d expected=%0d prev=%0d", i, got, exp_v, prev);
      end
      if (i < 4) begin
        checks++;
        if (got !== first[i]) begin
          errors++;
          $display("FAIL step_up_seq cyc%0d v_out=%0d expected=%0d", i, got, first[i]);
        end
      end
      prev = got;
    end
    checks++;
    if (got !== 8'd64) begin
      errors++;
      $display("FAIL step_up_final v_out=%0d expected=64", got);
    end
  endtask

  task automatic test_step_down();
    logic [7:0] first [2] = '{8'd56, 8'd49};
    prev = 8'd64;
    for (int i = 0; i < 64; i++) begin
      cyc(8'd0, 1'b1);
      checks++;
      if (got !== exp_v || got > prev) begin
        errors++;
        $display("FAIL step_down cyc%0d v_out=%0d expected=%0d prev=%0d", i, got, exp_v, prev);
      end
      if (i < 2) begin
        checks++;
        if (got !== first[i]) begin
          errors++;
          $display("FAIL step_down_seq cyc%0d v_out=%0d expected=%0d", i, got, first[i]);
        end
      end
      prev = got;
    end
    checks++;
    if (got !== 8'd0) begin
      errors++;
      $display("FAIL step_down_final v_out=%0d expected=0", got);
    end
  endtask

  task automatic test_staircase();
    logic [7:0] lv [4] = '{8'd32, 8'd64, 8'd32, 8'd0};
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 64; i++) begin
        cyc(lv[s], 1'b1);
        checks++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL stair s%0d cyc%0d v_out=%0d expected=%0d", s, i, got, exp_v);
        end
      end
      checks++;
      if (got !== lv[s]) begin
        errors++;
        $display("FAIL stair_end s%0d v_out=%0d expected=%0d", s, got, lv[s]);
      end
    end
  endtask

  task automatic test_full_scale();
    prev = 8'd0;
    for (int i = 0; i < 100; i++) begin
      cyc(8'd255, 1'b1);
      checks++;
      if (got !== exp_v || got < prev) begin
        errors++;
        $display("FAIL full cyc%0d v_out=%0d expected=%0d prev=%0d", i, got, exp_v, prev);
      end
      prev = got;
    end
    checks++;
    if (got !== 8'd255) begin
      errors++;
      $display("FAIL full_final v_out=%0d expected=255", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq [6] = '{8'd8, 8'd15, 8'd21, 8'd0, 8'd8, 8'd15};
    cyc(8'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(8'd64, i != 3);
      checks++;
      if (got !== seq[i] || got !== exp_v) begin
        errors++;
        $display("FAIL reset_mid cyc%0d v_out=%0d expected=%0d", i, got, seq[i]);
      end
    end
  endtask

  initial begin
    bus.v_in = 8'd0;
    rst = 1'b0;
    test_reset();
    test_zero();
    test_step_up();
    test_step_down();
    test_staircase();
    test_full_scale();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
